ram_burst_reader: RTL and testbench

//  Bus-side reader for the CPU block-transfer port. Issues one RamToOut command for a burst
//  (up to LANES words from start_addr), captures the LANES-wide parallel result, then emits
//  the words one per handshake on a serial valid/ready stream. Sits beside the host path on
//  the CPU command mux; it drives the port only while cmd_en=1.

---
 rtl/ram_burst_reader.sv | 152 +++++++++++++++
 tb/tb_ram_burst_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst reader for the CPU block-transfer port: one RamToOut command per burst,
// parallel capture of the returned lanes, then a serial valid/ready word stream.
module ram_burst_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int LANES  = 16,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [CNT_W-1:0]        start_cnt,
  output logic                    cmd_en,
  output logic [2:0]              cmd_op,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [CNT_W-1:0]        cmd_cnt,
  input  logic [LANES*DATA_W-1:0] ram_output,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [CNT_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    out_oob,
  output logic                    busy,
  output logic                    done
);

  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, STREAM, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] buffer [LANES];
  logic [LANES-1:0]  oob_reg;
  logic [LANES-1:0]  lane_oob;
  logic              valid_reg, last_reg, word_oob_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  index_reg;
  logic [CNT_W-1:0]  index_next;
  logic              handshake;

  assign handshake  = valid_reg & out_ready;
  assign index_next = index_reg + 1'b1;

  // A lane is out of range when the 9-bit address sum carries; no wrap to 0.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [AW1-1:0] lane_addr;
      assign lane_addr    = {1'b0, addr_reg} + AW1'(gi);
      assign lane_oob[gi] = lane_addr[ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE: begin
        cmd_en     = 1'b1;
        busy       = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (handshake && last_reg) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane buffer carries no reset: its contents are only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (state_reg == CAPTURE) begin
      for (int i = 0; i < LANES; i++) begin
        if (CNT_W'(i) <= cnt_reg)
          buffer[i] <= lane_oob[i] ? '0 : ram_output[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      cnt_reg      <= '0;
      oob_reg      <= '0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      index_reg    <= '0;
      last_reg     <= 1'b0;
      word_oob_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        addr_reg <= start_addr;
        cnt_reg  <= start_cnt;
      end
      if (state_reg == CAPTURE) oob_reg <= lane_oob;
      if (state_reg == STREAM) begin
        // First STREAM cycle loads word 0 from the freshly captured buffer.
        if (!valid_reg) begin
          valid_reg    <= 1'b1;
          index_reg    <= '0;
          data_reg     <= buffer[0];
          word_oob_reg <= oob_reg[0];
          last_reg     <= (cnt_reg == '0);
        end else if (handshake) begin
          if (last_reg) begin
            valid_reg    <= 1'b0;
            index_reg    <= '0;
            data_reg     <= '0;
            word_oob_reg <= 1'b0;
            last_reg     <= 1'b0;
          end else begin
            index_reg    <= index_next;
            data_reg     <= buffer[index_next];
            word_oob_reg <= oob_reg[index_next];
            last_reg     <= (index_next == cnt_reg);
          end
        end
      end
    end
  end

  assign cmd_op    = 3'b100;
  assign cmd_addr  = addr_reg;
  assign cmd_cnt   = cnt_reg;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_index = index_reg;
  assign out_last  = last_reg;
  assign out_oob   = word_oob_reg;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a CPU/RAM model answers commands, expected
// words are queued at start and compared as the stream produces them.
module tb_ram_burst_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int LANES  = 16;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [ADDR_W-1:0]       start_addr;
  logic [CNT_W-1:0]        start_cnt;
  logic                    cmd_en;
  logic [2:0]              cmd_op;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [CNT_W-1:0]        cmd_cnt;
  logic [LANES*DATA_W-1:0] ram_output = '0;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [CNT_W-1:0]        out_index;
  logic                    out_last;
  logic                    out_oob;
  logic                    busy;
  logic                    done;

  ram_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .start_cnt(start_cnt),
    .cmd_en(cmd_en), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_cnt(cmd_cnt),
    .ram_output(ram_output), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .out_oob(out_oob),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  idx;
    logic              last;
    logic              oob;
  } exp_t;

  logic [DATA_W-1:0] ram [512];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cmd_en_count = 0;
  int   hs_count = 0;
  bit   bp_mode = 0;
  int   pc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // CPU model: executes RamToOut on the edge closing ISSUE; unused/oob lanes carry junk.
  always @(posedge clk) begin
    if (cmd_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i <= int'(cmd_cnt) && int'(cmd_addr) + i < 512)
          ram_output[i*DATA_W +: DATA_W] <= ram[int'(cmd_addr) + i];
        else
          ram_output[i*DATA_W +: DATA_W] <= 32'hBAD0_0000 | i;
      end
    end
  end

  // out_ready changes just after the rising edge so the negedge monitor sees a stable value.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode) begin
        out_ready = (pc % 3 == 0);
        pc++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cmd_en) cmd_en_count++;
        if (out_valid) begin
          check_eq("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            check_eq("data", out_data, e.d);
            check_eq("index", out_index, e.idx);
            check_eq("last", out_last, e.last);
            check_eq("oob", out_oob, e.oob);
            $display("word idx=%0d data=%08h last=%0b oob=%0b ready=%0b",
                     out_index, out_data, out_last, out_oob, out_ready);
            if (out_ready) begin
              void'(exp_q.pop_front());
              hs_count++;
            end
          end
        end
      end
    end
  end

  task automatic push_expected(input int a, input int c);
    exp_t e;
    for (int i = 0; i <= c; i++) begin
      e.oob  = (a + i >= 512);
      e.d    = e.oob ? '0 : ram[a + i];
      e.idx  = CNT_W'(i);
      e.last = (i == c);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_en"}, cmd_en, 0);
    check_eq({tag, "_cmd_op"}, cmd_op, 3'b100);
    check_eq({tag, "_cmd_addr"}, cmd_addr, 0);
    check_eq({tag, "_cmd_cnt"}, cmd_cnt, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_index"}, out_index, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_out_oob"}, out_oob, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  task automatic run_burst(input int a, input int c, input bit bp, input bit poke);
    int cmd_before, hs_before, dcyc;
    bp_mode = bp;
    @(negedge clk);
    push_expected(a, c);
    cmd_before = cmd_en_count;
    hs_before  = hs_count;
    start = 1'b1;
    start_addr = ADDR_W'(a);
    start_cnt  = CNT_W'(c);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("issue_cmd_en", cmd_en, 1);
    check_eq("issue_busy", busy, 1);
    check_eq("issue_cmd_addr", cmd_addr, a);
    check_eq("issue_cmd_cnt", cmd_cnt, c);
    check_eq("issue_cmd_op", cmd_op, 3'b100);
    @(posedge clk); #1;
    check_eq("capture_cmd_en", cmd_en, 0);
    @(posedge clk); #1;
    check_eq("n2_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check_eq("n3_out_valid", out_valid, 1);
    dcyc = 0;
    for (int k = 1; k <= 300; k++) begin
      start = poke && (k == 2);
      start_addr = 9'd7;
      start_cnt  = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        dcyc = k;
        break;
      end
    end
    check_eq("done_seen", 64'(dcyc != 0), 1);
    check_eq("done_out_valid", out_valid, 0);
    check_eq("done_busy", busy, 0);
    if (!bp) check_eq("done_latency", dcyc, c + 1);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("after_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("handshakes", hs_count - hs_before, c + 1);
    check_eq("cmd_en_cycles", cmd_en_count - cmd_before, 1);
    $display("burst addr=%0d cnt=%0d bp=%0b poke=%0b done_after=%0d", a, c, bp, poke, dcyc);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int viol_done, viol_valid, viol_busy;
    for (int i = 0; i < 512; i++) ram[i] = $urandom;
    start = 1'b0;
    start_addr = '0;
    start_cnt  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(12, 15, 0, 0);
    run_burst(42, 3, 1, 0);
    run_burst(100, 0, 0, 0);
    run_burst(500, 15, 0, 0);
    run_burst(200, 7, 0, 1);
    for (int r = 0; r < 4; r++)
      run_burst(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)), bit'(r % 2), 0);

    // Abort mid-stream: reset must clear outputs immediately and suppress done.
    bp_mode = 0;
    @(negedge clk);
    push_expected(300, 15);
    start = 1'b1;
    start_addr = 9'd300;
    start_cnt  = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_abort_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    viol_done = 0;
    viol_valid = 0;
    viol_busy = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) viol_done++;
      if (out_valid) viol_valid++;
      if (busy) viol_busy++;
    end
    check_eq("abort_no_done", viol_done, 0);
    check_eq("abort_no_valid", viol_valid, 0);
    check_eq("abort_no_busy", viol_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
